shreg_serdes: RTL and testbench
===============================

Name: shreg_serdes

Overview:
- Parametrised universal shift-register engine; successor to the fixed 4-bit PISO/SISO pair.
- One WIDTH-bit register supports parallel load and parallel read.
- Also supports serial transmit, either MSB- or LSB-first, and serial receive, with a programmable fill policy.
- Provides a start/done handshake, and sits between the parallel datapath and a serial link.

Parameters:
- WIDTH, 4: register length in bits; must be >= 2.
- MSB_FIRST, 1: 1 = shift toward MSB (bit WIDTH-1 exits first, fill enters at bit 0); 0 = shift toward LSB (bit 0 exits, fill enters at bit WIDTH-1).
- FILL, 0: fill source during TX. 0 = zero, 1 = rotate the exiting bit back in, 2 = ser_in (full-duplex SISO).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear/abort
- pl  in  1  parallel-load request
- par_in  in  WIDTH  parallel load data
- so  in  1  start serial transmit of WIDTH bits
- sl  in  1  start serial receive of WIDTH bits
- ser_in  in  1  serial input data
- ser_out  out  1  serial output; the current exit-end bit of the register
- ser_out_valid  out  1  high while in TX
- par_out  out  WIDTH  register contents (continuous)
- busy  out  1  high in TX or RX
- done  out  1  one-cycle pulse on completion
- cnt  out  CW  bits remaining in the current operation; CW = $clog2(WIDTH+1)

Behaviour:
- Reset (rst_n low, async): register=0, state=IDLE, cnt=0, done=0, busy=0, ser_out_valid=0, ser_out=0.
- States: IDLE, TX, RX. busy = (state != IDLE). ser_out_valid = (state == TX).
- ser_out = reg[WIDTH-1] if MSB_FIRST, else reg[0]. It is combinational from the register, so the first bit is visible before TX starts.
- done defaults to 0 every cycle unless set below.
- IDLE command priority, sampled at the edge: clr > pl > so > sl.
  - clr: register=0.
  - pl: register=par_in; state stays IDLE; no done.
  - so: state=TX, cnt=WIDTH.
  - sl: state=RX, cnt=WIDTH.
- TX: at each edge the register shifts one position; the vacated end takes the FILL source; cnt decrements.
  - Bit n (n=0..WIDTH-1) is on ser_out during TX cycle n.
  - On the edge where cnt==1: state=IDLE, cnt=0, done=1 for the following cycle.
  - TX lasts exactly WIDTH cycles.
- RX: at each edge ser_in is shifted into the fill end; cnt decrements.
  - After the WIDTH-th sample: state=IDLE, done=1 for one cycle.
  - par_out then holds the received word. With MSB_FIRST=1, the first bit received ends in bit WIDTH-1.
- While busy:
  - pl, so and sl are ignored; they are not queued.
  - clr aborts: register=0, state=IDLE, cnt=0, no done pulse.
- Starting a new op: pl/so/sl are accepted in the same cycle done is high, because state is already IDLE.
- Async reset mid-operation: immediate return to reset values; no done.
- FILL=1 with a full TX: the register returns to its pre-TX value.
- FILL=2: the TX shifts ser_in in simultaneously with shifting out, so one TX equals one full-duplex SISO word.
- Parameter checks: elaboration error if WIDTH<2 or FILL>2.

Test Plan:
- WIDTH=4, MSB_FIRST=1, FILL=0: pl with par_in=4'b1011, then so -> ser_out=1,0,1,1 over 4 TX cycles; ser_out_valid high for 4 cycles; done pulses once; par_out=0000 afterwards.
- Same load with FILL=1 -> serial sequence 1,0,1,1; par_out=1011 after done.
- MSB_FIRST=0, par_in=4'b1011 -> ser_out sequence 1,1,0,1 (LSB-first).
- sl with ser_in=1,1,0,1 on 4 consecutive edges (MSB_FIRST=1) -> par_out=4'b1101; done high one cycle; busy high exactly 4 cycles.
- FILL=2, load 4'b1010, so with ser_in=0,1,1,0 -> ser_out=1,0,1,0 and final par_out=4'b0110.
- Priority and abort:
  - pl and so together in IDLE -> load only, no TX.
  - so asserted during TX -> ignored.
  - clr after 2 TX bits -> par_out=0, busy=0, no done.
  - rst_n low mid-RX -> all outputs at reset values immediately.

Source files
------------

// File: rtl/shreg_serdes.sv
// Universal WIDTH-bit shift register: parallel load/read, serial TX (MSB- or LSB-first,
// programmable fill) and serial RX, with a start/done handshake.
module shreg_serdes #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned FILL      = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         pl,
    input  logic [WIDTH-1:0]             par_in,
    input  logic                         so,
    input  logic                         sl,
    input  logic                         ser_in,
    output logic                         ser_out,
    output logic                         ser_out_valid,
    output logic [WIDTH-1:0]             par_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   cnt
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || FILL > 2) begin : g_param_check
        $error("shreg_serdes: WIDTH must be >= 2 and FILL must be 0, 1 or 2");
    end

    typedef enum logic [1:0] {StIdle, StTx, StRx} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             exit_bit, in_bit;

    assign exit_bit = MSB_FIRST ? reg_q[WIDTH-1] : reg_q[0];

    // RX always shifts ser_in; TX fill depends on FILL.
    always_comb begin
        in_bit = 1'b0;
        if (state_q == StRx || FILL == 2) begin
            in_bit = ser_in;
        end else if (FILL == 1) begin
            in_bit = exit_bit;
        end
    end

    assign shifted = MSB_FIRST ? {reg_q[WIDTH-2:0], in_bit} : {in_bit, reg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (clr) begin
            reg_d   = '0;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pl) begin
                        reg_d = par_in;
                    end else if (so) begin
                        state_d = StTx;
                        cnt_d   = CW'(WIDTH);
                    end else if (sl) begin
                        state_d = StRx;
                        cnt_d   = CW'(WIDTH);
                    end
                end
                StTx, StRx: begin
                    reg_d = shifted;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            reg_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign ser_out       = exit_bit;
    assign ser_out_valid = (state_q == StTx);
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign cnt           = cnt_q;
    assign par_out       = reg_q;

endmodule

// File: tb/tb_shreg_serdes.sv
// Bench for shreg_serdes: five parameterisations driven in parallel, directed scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_shreg_serdes;

    localparam int W  = 4;
    localparam int NI = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clr = 1'b0, pl = 1'b0, so = 1'b0, sl = 1'b0, ser_in = 1'b0;
    logic [W-1:0] par_in = '0;

    logic [W-1:0] po   [NI];
    logic         sout [NI];
    logic         sval [NI];
    logic         bsy  [NI];
    logic         dn   [NI];
    logic [2:0]   cn   [NI];

    // Instance order: M1F0, M1F1, M0F0, M1F2, M0F2.
    int msb_a [NI] = '{1, 1, 0, 1, 0};
    int fil_a [NI] = '{0, 1, 0, 2, 2};

    int m_st [NI];   // 0 idle, 1 tx, 2 rx
    int m_word [NI];
    int m_k [NI];    // bits shifted so far in the current op
    int m_acc [NI];  // fill bits accumulated so far
    bit m_done [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shreg_serdes #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pl(pl), .par_in(par_in), .so(so), .sl(sl),
        .ser_in(ser_in), .ser_out(sout[0]), .ser_out_valid(sval[0]), .par_out(po[0]),
        .busy(bsy[0]), .done(dn[0]), .cnt(cn[0]));
    shreg_serdes #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pl(pl), .par_in(par_in), .so(so), .sl(sl),
        .ser_in(ser_in), .ser_out(sout[1]), .ser_out_valid(sval[1]), .par_out(po[1]),
        .busy(bsy[1]), .done(dn[1]), .cnt(cn[1]));
    shreg_serdes #(.WIDTH(W), .MSB_FIRST(1'b0), .FILL(0)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pl(pl), .par_in(par_in), .so(so), .sl(sl),
        .ser_in(ser_in), .ser_out(sout[2]), .ser_out_valid(sval[2]), .par_out(po[2]),
        .busy(bsy[2]), .done(dn[2]), .cnt(cn[2]));
    shreg_serdes #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL(2)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pl(pl), .par_in(par_in), .so(so), .sl(sl),
        .ser_in(ser_in), .ser_out(sout[3]), .ser_out_valid(sval[3]), .par_out(po[3]),
        .busy(bsy[3]), .done(dn[3]), .cnt(cn[3]));
    shreg_serdes #(.WIDTH(W), .MSB_FIRST(1'b0), .FILL(2)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pl(pl), .par_in(par_in), .so(so), .sl(sl),
        .ser_in(ser_in), .ser_out(sout[4]), .ser_out_valid(sval[4]), .par_out(po[4]),
        .busy(bsy[4]), .done(dn[4]), .cnt(cn[4]));

    // Register = remaining original word shifted by k, with the k fill bits at the fill end.
    function automatic int exp_reg(int i);
        if (msb_a[i] != 0) return ((m_word[i] << m_k[i]) & ((1 << W) - 1)) | m_acc[i];
        return (m_word[i] >> m_k[i]) | (m_acc[i] << (W - m_k[i]));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_st[i] = 0; m_word[i] = 0; m_k[i] = 0; m_acc[i] = 0; m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            int r;
            int b;
            r = exp_reg(i);
            m_done[i] = 1'b0;
            if (!rst_n || clr) begin
                m_st[i] = 0; m_word[i] = 0; m_k[i] = 0; m_acc[i] = 0;
            end else if (m_st[i] == 0) begin
                if (pl) m_word[i] = int'(par_in);
                else if (so) m_st[i] = 1;
                else if (sl) m_st[i] = 2;
            end else begin
                if (m_st[i] == 2 || fil_a[i] == 2) b = int'(ser_in);
                else if (fil_a[i] == 1) b = (msb_a[i] != 0) ? (r >> (W - 1)) & 1 : r & 1;
                else b = 0;
                if (msb_a[i] != 0) m_acc[i] = (m_acc[i] << 1) | b;
                else m_acc[i] = m_acc[i] | (b << m_k[i]);
                m_k[i]++;
                if (m_k[i] == W) begin
                    m_word[i] = exp_reg(i);
                    m_st[i] = 0; m_k[i] = 0; m_acc[i] = 0; m_done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({po[i], sout[i], sval[i], bsy[i], dn[i], cn[i]} !== '0) begin
                n_err++;
                $display("FAIL reset u%0d: got po=%b so=%b v=%b busy=%b done=%b cnt=%0d want 0",
                         i, po[i], sout[i], sval[i], bsy[i], dn[i], cn[i]);
            end
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_tx_load();
        bit seq_m [4] = '{1, 0, 1, 1};
        bit seq_l [4] = '{1, 1, 0, 1};
        pl = 1'b1; par_in = 4'b1011; ser_in = 1'b0;
        cycle();
        pl = 1'b0; so = 1'b1;
        cycle();
        so = 1'b0;
        for (int n = 0; n < 4; n++) begin
            n_vec++;
            if (sout[0] !== seq_m[n] || sout[1] !== seq_m[n] || sout[2] !== seq_l[n] ||
                sval[0] !== 1'b1 || dn[0] !== 1'b0 || cn[0] !== 3'(4 - n)) begin
                n_err++;
                $display("FAIL tx_bit%0d: got so=%b/%b/%b v=%b done=%b cnt=%0d want %b/%b/%b 1 0 %0d",
                         n, sout[0], sout[1], sout[2], sval[0], dn[0], cn[0],
                         seq_m[n], seq_m[n], seq_l[n], 4 - n);
            end
            cycle();
        end
        n_vec++;
        if (dn[0] !== 1'b1 || dn[2] !== 1'b1 || sval[0] !== 1'b0 || bsy[0] !== 1'b0 ||
            po[0] !== 4'b0000 || po[1] !== 4'b1011 || po[2] !== 4'b0000) begin
            n_err++;
            $display("FAIL tx_end: got done=%b/%b v=%b busy=%b po=%b/%b/%b want 1/1 0 0 0000/1011/0000",
                     dn[0], dn[2], sval[0], bsy[0], po[0], po[1], po[2]);
        end
        cycle();
        n_vec++;
        if (dn[0] !== 1'b0) begin
            n_err++;
            $display("FAIL tx_done_width: got done=%b want 0", dn[0]);
        end
    endtask

    task automatic test_rx();
        bit rxb [4] = '{1, 1, 0, 1};
        sl = 1'b1;
        cycle();
        sl = 1'b0;
        for (int n = 0; n < 4; n++) begin
            n_vec++;
            if (bsy[0] !== 1'b1 || sval[0] !== 1'b0) begin
                n_err++;
                $display("FAIL rx_busy%0d: got busy=%b v=%b want 1 0", n, bsy[0], sval[0]);
            end
            ser_in = rxb[n];
            cycle();
        end
        n_vec++;
        if (po[0] !== 4'b1101 || po[2] !== 4'b1011 || dn[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rx_end: got po=%b/%b done=%b busy=%b want 1101/1011 1 0",
                     po[0], po[2], dn[0], bsy[0]);
        end
        cycle();
    endtask

    task automatic test_fill2();
        bit sib   [4] = '{0, 1, 1, 0};
        bit seq_m [4] = '{1, 0, 1, 0};
        bit seq_l [4] = '{0, 1, 0, 1};
        pl = 1'b1; par_in = 4'b1010;
        cycle();
        pl = 1'b0; so = 1'b1;
        cycle();
        so = 1'b0;
        for (int n = 0; n < 4; n++) begin
            n_vec++;
            if (sout[3] !== seq_m[n] || sout[4] !== seq_l[n]) begin
                n_err++;
                $display("FAIL fill2_bit%0d: got so=%b/%b want %b/%b",
                         n, sout[3], sout[4], seq_m[n], seq_l[n]);
            end
            ser_in = sib[n];
            cycle();
        end
        n_vec++;
        if (po[3] !== 4'b0110 || po[4] !== 4'b0110 || po[1] !== 4'b1010) begin
            n_err++;
            $display("FAIL fill2_end: got po=%b/%b rot=%b want 0110/0110 1010", po[3], po[4], po[1]);
        end
        cycle();
    endtask

    task automatic test_priority_abort();
        pl = 1'b1; so = 1'b1; par_in = 4'b0110;
        cycle();
        pl = 1'b0; so = 1'b0;
        n_vec++;
        if (bsy[0] !== 1'b0 || po[0] !== 4'b0110) begin
            n_err++;
            $display("FAIL pl_over_so: got busy=%b po=%b want 0 0110", bsy[0], po[0]);
        end
        so = 1'b1;
        cycle();
        cycle();
        cycle();
        n_vec++;
        if (bsy[0] !== 1'b1 || cn[0] !== 3'd2) begin
            n_err++;
            $display("FAIL so_ignored: got busy=%b cnt=%0d want 1 2", bsy[0], cn[0]);
        end
        so = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0;
        n_vec++;
        if (po[0] !== 4'b0000 || po[1] !== 4'b0000 || bsy[0] !== 1'b0 || dn[0] !== 1'b0 ||
            cn[0] !== 3'd0) begin
            n_err++;
            $display("FAIL clr_abort: got po=%b/%b busy=%b done=%b cnt=%0d want 0000/0000 0 0 0",
                     po[0], po[1], bsy[0], dn[0], cn[0]);
        end
        cycle();
        n_vec++;
        if (dn[0] !== 1'b0) begin
            n_err++;
            $display("FAIL clr_no_done: got done=%b want 0", dn[0]);
        end
    endtask

    task automatic test_async_reset();
        pl = 1'b1; par_in = 4'b1111;
        cycle();
        pl = 1'b0; sl = 1'b1;
        cycle();
        sl = 1'b0; ser_in = 1'b1;
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({po[i], sout[i], sval[i], bsy[i], dn[i], cn[i]} !== '0) begin
                n_err++;
                $display("FAIL async_rst u%0d: got po=%b so=%b v=%b busy=%b done=%b cnt=%0d want 0",
                         i, po[i], sout[i], sval[i], bsy[i], dn[i], cn[i]);
            end
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            clr    = ($urandom_range(0, 24) == 0);
            pl     = ($urandom_range(0, 5) == 0);
            so     = ($urandom_range(0, 3) == 0);
            sl     = ($urandom_range(0, 3) == 0);
            ser_in = 1'($urandom);
            par_in = 4'($urandom);
            cycle();
            for (int i = 0; i < NI; i++) begin
                int         er;
                logic [3:0] ep;
                logic       es;
                logic [2:0] ec;
                er = exp_reg(i);
                ep = er[3:0];
                es = (msb_a[i] != 0) ? ep[W-1] : ep[0];
                ec = (m_st[i] != 0) ? 3'(W - m_k[i]) : 3'd0;
                n_vec++;
                if (po[i] !== ep || sout[i] !== es || sval[i] !== (m_st[i] == 1) ||
                    bsy[i] !== (m_st[i] != 0) || dn[i] !== m_done[i] || cn[i] !== ec) begin
                    n_err++;
                    $display("FAIL random c%0d u%0d: got po=%b so=%b v=%b busy=%b done=%b cnt=%0d want po=%b so=%b v=%b busy=%b done=%b cnt=%0d",
                             c, i, po[i], sout[i], sval[i], bsy[i], dn[i], cn[i],
                             ep, es, m_st[i] == 1, m_st[i] != 0, m_done[i], ec);
                end
            end
        end
        clr = 1'b0; pl = 1'b0; so = 1'b0; sl = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tx_load();
        test_rx();
        test_fill2();
        test_priority_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
